mdu_iter: RTL and testbench



---
 rtl/mdu_iter.sv | 149 ++++++++++++++
 tb/tb_mdu_iter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU) with start/ready handshake and cancel.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational multiplier.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  stateT              state;
  logic [CNT_W-1:0]   cnt;
  logic               isDiv;
  logic               negQ;
  logic               negR;
  logic [WIDTH-1:0]   mOperand;
  logic [2*WIDTH-1:0] acc;

  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] mulStep(input logic [2*WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, x[2*WIDTH-1:WIDTH]} + (x[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, x[WIDTH-1:1]};
  endfunction

  // Remainder is kept WIDTH+1 bits wide after the shift so divisors with the MSB set still work.
  function automatic logic [2*WIDTH-1:0] divStep(input logic [2*WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] rem2;
    logic [WIDTH:0] diff;
    rem2 = x[2*WIDTH-1:WIDTH-1];
    diff = rem2 - {1'b0, d};
    if (!diff[WIDTH])
      return {diff[WIDTH-1:0], x[WIDTH-2:0], 1'b1};
    else
      return {rem2[WIDTH-1:0], x[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [2*WIDTH-1:0] fixUp(input logic [2*WIDTH-1:0] x,
                                               input logic div, input logic nq, input logic nr);
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    if (!div)
      return nq ? -x : x;
    rem = nr ? -x[2*WIDTH-1:WIDTH] : x[2*WIDTH-1:WIDTH];
    quo = nq ? -x[WIDTH-1:0] : x[WIDTH-1:0];
    return {rem, quo};
  endfunction

  logic               sgnOp;
  logic               accept;
  logic               divByZero;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] resFinal;

  assign sgnOp     = ~op[0];
  assign accept    = start && !cancel && (state == IDLE || state == DONE);
  assign busy      = (state == CALC) || accept;
  assign divByZero = op[1] && (b == '0);
  assign magA      = absVal(a, sgnOp);
  assign magB      = absVal(b, sgnOp);
  assign accNext   = isDiv ? divStep(acc, mOperand) : mulStep(acc, mOperand);
  assign resFinal  = fixUp(accNext, isDiv, negQ, negR);

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd;
  assign fastProd = fixUp({{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB}, 1'b0,
                          sgnOp & (a[WIDTH-1] ^ b[WIDTH-1]), 1'b0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            isDiv    <= op[1];
            negQ     <= sgnOp & (a[WIDTH-1] ^ b[WIDTH-1]);
            negR     <= sgnOp & a[WIDTH-1];
            mOperand <= op[1] ? magB : magA;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
            cnt      <= '0;
            if (divByZero) begin
              state    <= DONE;
              ready    <= 1'b1;
              hi       <= a;
              lo       <= '1;
              div_zero <= 1'b1;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!op[1]) begin
              state    <= DONE;
              ready    <= 1'b1;
              {hi, lo} <= fastProd;
              div_zero <= 1'b0;
            end
`endif
            else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            acc <= accNext;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state    <= DONE;
              ready    <= 1'b1;
              {hi, lo} <= resFinal;
              div_zero <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32): directed cases, cancel, reset, back-to-back and random ops.
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic BUSY_MID = 1'b0;
`else
  localparam int MUL_LAT = 33;
  localparam logic BUSY_MID = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divZero;

  int nAsserts = 0;
  int nFail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } expT;
  expT sb[$];

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .ready(ready), .hi(hi), .lo(lo), .div_zero(divZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00: begin p = sx * sy; return {1'b0, p}; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
        end else begin
          q = {32'b0, x} / {32'b0, y};
          r = {32'b0, x} % {32'b0, y};
        end
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Drives start at the current negedge; caller deasserts it.
  task automatic startOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic push, input logic [31:0] eHi, input logic [31:0] eLo,
                         input logic eDz, input int lat);
    expT e;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.hi = eHi; e.lo = eLo; e.dz = eDz; e.cyc = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkEq("drain", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic runModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] m;
    int lat;
    m = model(o, x, y);
    lat = !o[1] ? MUL_LAT : (y == 32'd0 ? 1 : 33);
    @(negedge clk);
    startOp(o, x, y, 1'b1, m[63:32], m[31:0], m[64], lat);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        checkEq("spurious_ready", 64'd1, 64'd0);
      end else begin
        expT e;
        e = sb.pop_front();
        checkEq("hi", 64'(hi), 64'(e.hi));
        checkEq("lo", 64'(lo), 64'(e.lo));
        checkEq("div_zero", 64'(divZero), 64'(e.dz));
        checkEq("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checkEq("rst_busy", 64'(busy), 64'd0);
    checkEq("rst_ready", 64'(ready), 64'd0);
    checkEq("rst_hi", 64'(hi), 64'd0);
    checkEq("rst_lo", 64'(lo), 64'd0);
    checkEq("rst_dz", 64'(divZero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // signed multiply with busy profile
    startOp(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT);
    #1 checkEq("mult_busy_c0", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    checkEq("mult_busy_c32", 64'(busy), 64'(BUSY_MID));
    @(negedge clk);
    checkEq("mult_busy_c33", 64'(busy), 64'd0);
    drain();

    // signed and unsigned divide
    @(negedge clk);
    startOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    @(negedge clk); start = 1'b0;
    drain();
    startOp(2'b11, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'hF, 32'h0FFF_FFFF, 1'b0, 33);
    @(negedge clk); start = 1'b0;
    drain();

    // boundary divides
    startOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 33);
    @(negedge clk); start = 1'b0;
    drain();
    startOp(2'b11, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);
    @(negedge clk); start = 1'b0;
    drain();

    // cancel mid-divide, then start+cancel together in IDLE
    startOp(2'b11, 32'd100, 32'd3, 1'b0, '0, '0, 1'b0, 0);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkEq("cancel_idle_busy", 64'(busy), 64'd0);
    startOp(2'b01, 32'd2, 32'd2, 1'b0, '0, '0, 1'b0, 0);
    cancel = 1'b1;
    #1 checkEq("cancel_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    repeat (40) @(negedge clk);
    checkEq("cancel_hold_hi", 64'(hi), 64'd5);
    checkEq("cancel_hold_lo", 64'(lo), 64'hFFFF_FFFF);
    checkEq("cancel_hold_dz", 64'(divZero), 64'd1);

    // back-to-back with start pulsed mid-CALC
    startOp(2'b01, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0, MUL_LAT);
    @(negedge clk); start = 1'b0;
    repeat (MUL_LAT - 1) @(negedge clk);
    startOp(2'b11, 32'd9, 32'd2, 1'b1, 32'd1, 32'd4, 1'b0, 33);
    #1 checkEq("b2b_busy", 64'(busy), 64'd1);
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    startOp(2'b00, 32'h1234, 32'h5678, 1'b0, '0, '0, 1'b0, 0);
    @(negedge clk); start = 1'b0;
    drain();

    // reset mid-divide
    startOp(2'b10, 32'd1000, 32'd7, 1'b0, '0, '0, 1'b0, 0);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkEq("midrst_busy", 64'(busy), 64'd0);
    checkEq("midrst_ready", 64'(ready), 64'd0);
    checkEq("midrst_hi", 64'(hi), 64'd0);
    checkEq("midrst_lo", 64'(lo), 64'd0);
    runModel(2'b10, 32'd1000, 32'd7);

    // random mix against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) x = -x;
      runModel(o, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
